// File: rtl/stc_idx_scheduler_if.sv
// Mask-in / index-out handshake bundle between the metadata fetch stage,
// the index scheduler and the crossbar.
interface stc_idx_scheduler_if #(
    parameter int unsigned N_IN   = 32,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned DW_IDX = 5
);
    logic                      mask_valid;
    logic                      mask_ready;
    logic [N_IN-1:0]           mask;
    logic                      idx_valid;
    logic                      idx_ready;
    logic [N_OUT*DW_IDX-1:0]   idx;
    logic [N_OUT-1:0]          lane_en;
    logic                      idx_last;
    logic                      busy;

    // Producer of masks and consumer of index beats.
    modport master (
        output mask_valid, mask, idx_ready,
        input  mask_ready, idx_valid, idx, lane_en, idx_last, busy
    );

    // The scheduler itself.
    modport slave (
        input  mask_valid, mask, idx_ready,
        output mask_ready, idx_valid, idx, lane_en, idx_last, busy
    );
endinterface

// File: rtl/stc_idx_scheduler.sv
// Issues the set-bit positions of each accepted nonzero mask as beats of up
// to N_OUT crossbar indices, lowest positions first.
module stc_idx_scheduler #(
    parameter int unsigned N_IN   = 32,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned DW_IDX = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    stc_idx_scheduler_if.slave    bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                    state_q, state_d;
    logic [N_IN-1:0]           rem_q, rem_d;
    logic                      armed_q;

    logic [N_IN-1:0]           cur;
    logic [N_IN-1:0]           rest;
    logic [N_OUT*DW_IDX-1:0]   idx_c;
    logic [N_OUT-1:0]          lane_c;
    logic                      last_c;
    logic                      ready_c;
    logic                      valid_c;

    // Cascade of N_OUT find-first-set stages over the unissued bits.
    always_comb begin
        cur    = rem_q;
        idx_c  = '0;
        lane_c = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            lane_c[k] = |cur;
            for (int i = int'(N_IN) - 1; i >= 0; i--) begin
                if (cur[i]) idx_c[k*DW_IDX +: DW_IDX] = DW_IDX'(i);
            end
            cur = cur & (cur - N_IN'(1));
        end
        rest = cur;
    end

    // Anything left after N_OUT picks means more beats follow.
    assign last_c = (state_q == BUSY) && (rest == '0);

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ready_c = 1'b0;
        valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = armed_q;
                if (bus.mask_valid && armed_q) begin
                    state_d = BUSY;
                    rem_d   = bus.mask;
                end
            end
            BUSY: begin
                valid_c = 1'b1;
                ready_c = last_c && bus.idx_ready;
                if (bus.idx_ready) begin
                    if (!last_c) begin
                        rem_d = rest;
                    end else if (bus.mask_valid) begin
                        rem_d = bus.mask;
                    end else begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // armed_q holds mask_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            armed_q <= 1'b1;
        end
    end

    assign bus.mask_ready = ready_c;
    assign bus.idx_valid  = valid_c;
    assign bus.idx        = idx_c;
    assign bus.lane_en    = lane_c;
    assign bus.idx_last   = last_c;
    assign bus.busy       = (state_q == BUSY);

endmodule

// File: tb/tb_stc_idx_scheduler.sv
// Directed bench for stc_idx_scheduler with a queue of expected beats.
module tb_stc_idx_scheduler;

    localparam int unsigned N_IN   = 32;
    localparam int unsigned N_OUT  = 4;
    localparam int unsigned DW_IDX = 5;

    typedef struct packed {
        logic [N_OUT*DW_IDX-1:0] idx;
        logic [N_OUT-1:0]        lane;
        logic                    last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];

    stc_idx_scheduler_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW_IDX(DW_IDX)) bus ();

    stc_idx_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .DW_IDX(DW_IDX)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference split of a mask into beats, lowest positions first.
    task automatic push_row(input logic [N_IN-1:0] m);
        beat_t b;
        beat_t rows[$];
        int    n;
        b = '0;
        n = 0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (m[i]) begin
                b.idx[n*DW_IDX +: DW_IDX] = DW_IDX'(i);
                b.lane[n] = 1'b1;
                n++;
                if (n == int'(N_OUT)) begin
                    rows.push_back(b);
                    b = '0;
                    n = 0;
                end
            end
        end
        if (n != 0 || rows.size() == 0) rows.push_back(b);
        rows[rows.size()-1].last = 1'b1;
        foreach (rows[j]) sb.push_back(rows[j]);
    endtask

    // Offer a mask until it is accepted on a rising edge.
    task automatic send(input logic [N_IN-1:0] m);
        bit ok;
        ok = 1'b0;
        @(posedge clk) #1;
        bus.mask_valid = 1'b1;
        bus.mask       = m;
        push_row(m);
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus.mask_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk) #1;
        bus.mask_valid = 1'b0;
    endtask

    // Wait for all expected beats, then confirm the block went idle.
    task automatic drain(input string tag);
        for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
        chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_idle_valid"}, 32'(bus.idx_valid), 32'd0);
        chk({tag, "_idle_busy"},  32'(bus.busy), 32'd0);
    endtask

    // Compare every handshaked beat against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.idx_valid === 1'b1 && bus.idx_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(bus.lane_en), 32'hDEAD);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_idx",  32'(bus.idx), 32'(e.idx));
                chk("beat_lane", 32'(bus.lane_en), 32'(e.lane));
                chk("beat_last", 32'(bus.idx_last), 32'(e.last));
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.mask_valid = 1'b0;
        bus.mask       = '0;
        bus.idx_ready  = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mask_ready", 32'(bus.mask_ready), 32'd0);
        chk("rst_idx_valid",  32'(bus.idx_valid), 32'd0);
        chk("rst_idx",        32'(bus.idx), 32'd0);
        chk("rst_lane_en",    32'(bus.lane_en), 32'd0);
        chk("rst_idx_last",   32'(bus.idx_last), 32'd0);
        chk("rst_busy",       32'(bus.busy), 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.mask_ready), 32'd1);

        // Single full beat.
        send(32'h0000_4032);
        drain("m4032");

        // Two-beat row.
        send(32'h0100_C812);
        drain("mC812");

        // Empty and full masks.
        send(32'h0000_0000);
        drain("empty");
        send(32'hFFFF_FFFF);
        drain("full");

        // Backpressure on beat0 of a two-beat row.
        bus.idx_ready = 1'b0;
        send(32'h0100_C812);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.idx_valid), 32'd1);
            chk("bp_idx",   32'(bus.idx), 32'({5'd14, 5'd11, 5'd4, 5'd1}));
            chk("bp_lane",  32'(bus.lane_en), 32'b1111);
            chk("bp_last",  32'(bus.idx_last), 32'd0);
            chk("bp_ready", 32'(bus.mask_ready), 32'd0);
        end
        @(posedge clk) #1;
        bus.idx_ready = 1'b1;
        drain("bp");

        // Back-to-back rows with mask_valid held high.
        @(posedge clk) #1;
        bus.mask_valid = 1'b1;
        bus.mask       = 32'h0000_4032;
        push_row(32'h0000_4032);
        @(negedge clk);
        chk("b2b_accept1", 32'(bus.mask_ready), 32'd1);
        @(posedge clk) #1;
        bus.mask = 32'h0000_0003;
        push_row(32'h0000_0003);
        @(negedge clk);
        chk("b2b_beat1_valid", 32'(bus.idx_valid), 32'd1);
        chk("b2b_accept2",     32'(bus.mask_ready), 32'd1);
        @(posedge clk) #1;
        bus.mask_valid = 1'b0;
        @(negedge clk);
        chk("b2b_no_bubble", 32'(bus.idx_valid), 32'd1);
        drain("b2b");

        // Asynchronous reset in the middle of a full row.
        send(32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.idx_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.mask_ready), 32'd0);
        chk("mid_rst_idx",   32'(bus.idx), 32'd0);
        chk("mid_rst_lane",  32'(bus.lane_en), 32'd0);
        chk("mid_rst_last",  32'(bus.idx_last), 32'd0);
        chk("mid_rst_busy",  32'(bus.busy), 32'd0);
        sb.delete();
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_mid_rst_valid", 32'(bus.idx_valid), 32'd0);
        send(32'h0000_0010);
        drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
